// File: rtl/aes_mixcols_seq.sv
// Sequential AES forward MixColumns: one 32-bit column per cycle, IDLE/BUSY/DONE handshake.
// Optional feature: define AES_MIXCOLS_BYPASS_EN to add a bypass input that passes the state through.
module aes_mixcols_seq (
  input  logic         clk,
  input  logic         reset,
`ifdef AES_MIXCOLS_BYPASS_EN
  input  logic         bypass,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]   r_state;
  logic [1:0]   r_cnt;
  logic [127:0] r_in;
  logic [127:0] r_res;
`ifdef AES_MIXCOLS_BYPASS_EN
  logic         r_bypass;
`endif

  logic [31:0]  w_col;
  logic [31:0]  w_mixed;
  logic [31:0]  w_col_out;
  logic [127:0] w_res_next;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] m0, m1, m2, m3;
    b0 = c[31:24];
    b1 = c[23:16];
    b2 = c[15:8];
    b3 = c[7:0];
    m0 = xtime(b0) ^ (xtime(b1) ^ b1) ^ b2 ^ b3;
    m1 = b0 ^ xtime(b1) ^ (xtime(b2) ^ b2) ^ b3;
    m2 = b0 ^ b1 ^ xtime(b2) ^ (xtime(b3) ^ b3);
    m3 = (xtime(b0) ^ b0) ^ b1 ^ b2 ^ xtime(b3);
    return {m0, m1, m2, m3};
  endfunction

  // Handshake outputs are forced low while reset is asserted.
  assign in_ready  = (r_state == StIdle) && !reset;
  assign out_valid = (r_state == StDone) && !reset;
  assign out_data  = r_res;

  always_comb begin
    w_col = r_in[127:96];
    unique case (r_cnt)
      2'd0: w_col = r_in[127:96];
      2'd1: w_col = r_in[95:64];
      2'd2: w_col = r_in[63:32];
      2'd3: w_col = r_in[31:0];
      default: w_col = r_in[127:96];
    endcase
  end

  assign w_mixed = mix_col(w_col);

`ifdef AES_MIXCOLS_BYPASS_EN
  assign w_col_out = r_bypass ? w_col : w_mixed;
`else
  assign w_col_out = w_mixed;
`endif

  always_comb begin
    w_res_next = r_res;
    unique case (r_cnt)
      2'd0: w_res_next[127:96] = w_col_out;
      2'd1: w_res_next[95:64]  = w_col_out;
      2'd2: w_res_next[63:32]  = w_col_out;
      2'd3: w_res_next[31:0]   = w_col_out;
      default: w_res_next = r_res;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= 2'd0;
      r_in    <= '0;
      r_res   <= '0;
`ifdef AES_MIXCOLS_BYPASS_EN
      r_bypass <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_in    <= in_data;
            r_cnt   <= 2'd0;
            r_state <= StBusy;
`ifdef AES_MIXCOLS_BYPASS_EN
            r_bypass <= bypass;
`endif
          end
        end
        StBusy: begin
          r_res <= w_res_next;
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
